// File: rtl/timeout_retry_ctrl.sv
// timeout_retry_ctrl
// Initiator-side request supervisor: launches a request towards the
// transmitter, arms a response timeout, re-sends on expiry up to max_retry
// times and reports done or fail to the requester.
//
// Handshake semantics (one place for all of them):
//   req_start : single-cycle pulse, only honoured while busy=0.
//   tx_req/tx_ack : tx_req is a level held from SEND entry until tx_ack is
//                   sampled high in SEND; tx_ack outside SEND is ignored.
//   rsp_valid : single-cycle pulse, only honoured in WAIT_RSP, never latched.
//   done/fail/timeout_evt : single-cycle registered pulses.
module timeout_retry_ctrl #(
  parameter int RETRY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_start,
  input  logic               abort,
  input  logic [31:0]        time_limit,
  input  logic [RETRY_W-1:0] max_retry,
  output logic               tx_req,
  input  logic               tx_ack,
  input  logic               rsp_valid,
  output logic               busy,
  output logic               done,
  output logic               fail,
  output logic               timeout_evt,
  output logic [RETRY_W-1:0] retry_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_RSP = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         cnt_q, cnt_d;
  logic [RETRY_W-1:0]  retry_cnt_q, retry_cnt_d;
  logic                tx_req_q, tx_req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic                timeout_evt_q, timeout_evt_d;

  // The counter is only ever incremented while it is below time_limit, so it
  // can reach at most 2^32-1 and never wraps.
  logic wait_expired;
  logic retry_left;

  // Expiry and retry-budget qualifiers, evaluated against the live inputs.
  always_comb begin
    wait_expired = (cnt_q >= time_limit);
    retry_left   = (retry_cnt_q < max_retry);
  end

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_cnt_d   = retry_cnt_q;
    done_d        = 1'b0;
    fail_d        = 1'b0;
    timeout_evt_d = 1'b0;

    if (abort) begin
      // Abort wins over everything except reset: drop straight to IDLE,
      // no completion pulse, retry_cnt keeps its value.
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req_start) begin
            state_d     = ST_SEND;
            retry_cnt_d = '0;
          end
        end
        ST_SEND: begin
          // No timeout on the ack phase; wait as long as it takes.
          if (tx_ack) begin
            state_d = ST_WAIT_RSP;
            cnt_d   = '0;
          end
        end
        ST_WAIT_RSP: begin
          if (rsp_valid) begin
            // A response in the same cycle as expiry still counts as success.
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else if (wait_expired) begin
            if (retry_left) begin
              state_d       = ST_SEND;
              retry_cnt_d   = retry_cnt_q + RETRY_W'(1);
              timeout_evt_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
              fail_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Level outputs follow the state being entered so they are registered
    // and line up with the state register.
    tx_req_d = (state_d == ST_SEND);
    busy_d   = (state_d != ST_IDLE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      retry_cnt_q   <= '0;
      tx_req_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      fail_q        <= 1'b0;
      timeout_evt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_cnt_q   <= retry_cnt_d;
      tx_req_q      <= tx_req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      fail_q        <= fail_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign tx_req      = tx_req_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign fail        = fail_q;
  assign timeout_evt = timeout_evt_q;
  assign retry_cnt   = retry_cnt_q;

endmodule

// File: tb/tb_timeout_retry_ctrl.sv
// tb_timeout_retry_ctrl
// Bench for timeout_retry_ctrl: directed scenarios plus a randomized run,
// with a transaction-level reference model feeding an expected-output queue.
module tb_timeout_retry_ctrl;

  localparam int RW = 4;
  localparam int W  = 5 + RW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          req_start = 1'b0;
  logic          abort = 1'b0;
  logic [31:0]   time_limit = 32'd0;
  logic [RW-1:0] max_retry = '0;
  logic          tx_ack = 1'b0;
  logic          rsp_valid = 1'b0;
  logic          tx_req, busy, done, fail, timeout_evt;
  logic [RW-1:0] retry_cnt;

  timeout_retry_ctrl #(.RETRY_W(RW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_start   (req_start),
    .abort       (abort),
    .time_limit  (time_limit),
    .max_retry   (max_retry),
    .tx_req      (tx_req),
    .tx_ack      (tx_ack),
    .rsp_valid   (rsp_valid),
    .busy        (busy),
    .done        (done),
    .fail        (fail),
    .timeout_evt (timeout_evt),
    .retry_cnt   (retry_cnt)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Transaction view: a transaction is either free, waiting for the
  // transmitter to take the frame, or waiting for a reply since a known
  // cycle. Expiry is judged by elapsed-cycle arithmetic.
  localparam int PH_FREE = 0, PH_ACK = 1, PH_REPLY = 2;
  logic [W-1:0] exp_q[$];
  int     m_phase = PH_FREE;
  int     m_resends = 0;
  longint m_cycle = 0;
  longint m_reply_since = 0;

  always @(posedge clk) begin
    bit e_done, e_fail, e_evt;
    e_done = 0; e_fail = 0; e_evt = 0;
    m_cycle++;
    if (rst) begin
      m_phase = PH_FREE;
      m_resends = 0;
    end else if (abort) begin
      m_phase = PH_FREE;
    end else if (m_phase == PH_FREE) begin
      if (req_start) begin
        m_phase = PH_ACK;
        m_resends = 0;
      end
    end else if (m_phase == PH_ACK) begin
      if (tx_ack) begin
        m_phase = PH_REPLY;
        m_reply_since = m_cycle + 1;
      end
    end else begin
      if (rsp_valid) begin
        e_done = 1;
        m_phase = PH_FREE;
      end else if ((m_cycle - m_reply_since) >= longint'(time_limit)) begin
        if (m_resends < int'(max_retry)) begin
          m_resends++;
          e_evt = 1;
          m_phase = PH_ACK;
        end else begin
          e_fail = 1;
          m_phase = PH_FREE;
        end
      end
    end
    exp_q.push_back({m_phase == PH_ACK, m_phase != PH_FREE, e_done, e_fail, e_evt,
                     RW'(m_resends)});
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("outputs{tx_req,busy,done,fail,tevt,retry}",
            32'({tx_req, busy, done, fail, timeout_evt, retry_cnt}), 32'(e));
    end
  end

  // ---------------- pulse monitor on DUT outputs ----------------
  int  n_txrise = 0, n_tevt = 0, n_fail = 0, n_done = 0;
  int  cyc = 0, wait_entry = 0, gap_min = 0, gap_max = 0;
  logic tx_req_prev = 1'b0;

  always @(negedge clk) begin
    int g;
    cyc++;
    if (tx_req === 1'b1 && tx_req_prev === 1'b0) n_txrise++;
    if (tx_req === 1'b0 && tx_req_prev === 1'b1 && busy === 1'b1) wait_entry = cyc;
    if (timeout_evt === 1'b1 || fail === 1'b1) begin
      g = cyc - wait_entry;
      if (gap_min == 0 || g < gap_min) gap_min = g;
      if (g > gap_max) gap_max = g;
    end
    if (timeout_evt === 1'b1) n_tevt++;
    if (fail === 1'b1) n_fail++;
    if (done === 1'b1) n_done++;
    tx_req_prev = tx_req;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_txrise = 0; n_tevt = 0; n_fail = 0; n_done = 0;
    gap_min = 0; gap_max = 0;
  endtask

  task automatic pulse_req();
    req_start = 1'b1;
    tick();
    req_start = 1'b0;
  endtask

  task automatic pulse_ack();
    tx_ack = 1'b1;
    tick();
    tx_ack = 1'b0;
  endtask

  task automatic wait_tevt_or_fail(input string name, input int budget, input bit want_fail);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (want_fail ? (fail === 1'b1) : (timeout_evt === 1'b1)) seen = 1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) tick();
    rst = 1'b0;
    check("reset_outputs", 32'({tx_req, busy, done, fail, timeout_evt, retry_cnt}), 32'd0);

    // 1: immediate success
    time_limit = 32'd10; max_retry = RW'(2);
    clear_counts();
    pulse_req();
    check("t1_tx_req_after_start", 32'(tx_req), 32'd1);
    check("t1_busy_after_start", 32'(busy), 32'd1);
    pulse_ack();
    check("t1_tx_req_after_ack", 32'(tx_req), 32'd0);
    repeat (4) tick();
    rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_retry_cnt", 32'(retry_cnt), 32'd0);
    tick();
    check("t1_done_one_cycle", 32'(done), 32'd0);
    check("t1_no_tevt", 32'(n_tevt), 32'd0);

    // 2: exhausted retries with tx_ack held high
    time_limit = 32'd4; max_retry = RW'(2);
    tick();
    clear_counts();
    tx_ack = 1'b1;
    pulse_req();
    wait_tevt_or_fail("t2_fail_seen", 60, 1'b1);
    tx_ack = 1'b0;
    check("t2_tx_req_count", 32'(n_txrise), 32'd3);
    check("t2_tevt_count", 32'(n_tevt), 32'd2);
    check("t2_fail_count", 32'(n_fail), 32'd1);
    check("t2_retry_cnt", 32'(retry_cnt), 32'd2);
    check("t2_wait_len_min", 32'(gap_min), 32'd5);
    check("t2_wait_len_max", 32'(gap_max), 32'd5);
    tick();

    // 3: response in the same cycle the counter reaches time_limit
    time_limit = 32'd6; max_retry = RW'(1);
    clear_counts();
    pulse_req();
    pulse_ack();
    repeat (6) tick();
    rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    check("t3_done", 32'(done), 32'd1);
    check("t3_no_tevt", 32'(n_tevt), 32'd0);
    check("t3_no_fail", 32'(n_fail), 32'd0);
    tick();

    // 4: zero limits
    time_limit = 32'd0; max_retry = RW'(0);
    clear_counts();
    pulse_req();
    pulse_ack();
    tick();
    check("t4_fail", 32'(fail), 32'd1);
    check("t4_single_tx_req", 32'(n_txrise), 32'd1);
    check("t4_wait_len", 32'(gap_max), 32'd1);
    tick();

    // 5: abort after one retry, then reset while tx_req is high
    time_limit = 32'd3; max_retry = RW'(3);
    clear_counts();
    tx_ack = 1'b1;
    pulse_req();
    wait_tevt_or_fail("t5_first_tevt", 40, 1'b0);
    tick();
    abort = 1'b1; tick(); abort = 1'b0;
    tx_ack = 1'b0;
    check("t5_busy_after_abort", 32'(busy), 32'd0);
    check("t5_tx_req_after_abort", 32'(tx_req), 32'd0);
    check("t5_retry_cnt", 32'(retry_cnt), 32'd1);
    tick();
    check("t5_no_done_fail", 32'(n_done + n_fail), 32'd0);
    pulse_req();
    check("t5_tx_req_before_rst", 32'(tx_req), 32'd1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("t5_reset_outputs", 32'({tx_req, busy, done, fail, timeout_evt, retry_cnt}), 32'd0);

    // 6: ignored inputs
    time_limit = 32'd5; max_retry = RW'(1);
    clear_counts();
    pulse_req();
    req_start = 1'b1; rsp_valid = 1'b1; tick(); req_start = 1'b0; rsp_valid = 1'b0;
    check("t6_still_send", 32'({tx_req, busy, retry_cnt}), 32'({2'b11, RW'(0)}));
    pulse_ack();
    req_start = 1'b1; tick(); req_start = 1'b0;
    check("t6_still_wait", 32'({tx_req, busy}), 32'b01);
    rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    check("t6_done_late_rsp", 32'(done), 32'd1);
    check("t6_single_tx_req", 32'(n_txrise), 32'd1);
    pulse_ack();
    check("t6_ack_in_idle", 32'({tx_req, busy}), 32'd0);

    // randomized run
    for (int i = 0; i < 4000; i++) begin
      if (i % 60 == 0) begin
        time_limit = 32'($urandom_range(0, 9));
        max_retry  = ($urandom_range(0, 7) == 0) ? RW'($urandom_range(0, 15))
                                                 : RW'($urandom_range(0, 3));
      end
      req_start = ($urandom_range(0, 7) == 0);
      tx_ack    = ($urandom_range(0, 2) == 0);
      rsp_valid = ($urandom_range(0, 24) == 0);
      abort     = ($urandom_range(0, 149) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      tick();
    end
    req_start = 1'b0; tx_ack = 1'b0; rsp_valid = 1'b0; abort = 1'b0; rst = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
